// File: rtl/lmsm_sequencer.sv
// Decode-stage sequencer: passes ordinary instructions through with one cycle of latency and
// expands LM/SM into one micro-op per set mask bit, holding fetch while a sequence runs.
module lmsm_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir_in,
  input  logic        ir_valid,
  input  logic        stall_in,
  input  logic        flush,
  output logic        uop_valid,
  output logic [15:0] uop_ir,
  output logic [2:0]  uop_reg,
  output logic [15:0] uop_offset,
  output logic        first_multiple,
  output logic        last_multiple,
  output logic        fetch_hold
);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t      state, stateNext;
  logic [7:0]  rem, remNext;
  logic [2:0]  cnt, cntNext;

  logic        vld_p0;
  logic [15:0] uopIr_p0;
  logic [2:0]  uopReg_p0;
  logic [15:0] uopOffset_p0;
  logic        first_p0;
  logic        last_p0;

  logic        isMulti;
  logic [7:0]  mask;
  logic [2:0]  maskLow;
  logic [2:0]  remLow;
  logic [7:0]  maskLeft;
  logic [7:0]  remLeft;

  function automatic logic [2:0] lowBit(input logic [7:0] m);
    lowBit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowBit = 3'(i);
    end
  endfunction

  function automatic logic singleBit(input logic [7:0] m);
    return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
  endfunction

  assign isMulti  = (ir_in[15:13] == 3'b011);
  assign mask     = ir_in[7:0];
  assign maskLow  = lowBit(mask);
  assign remLow   = lowBit(rem);
  assign maskLeft = mask & ~(8'd1 << maskLow);
  assign remLeft  = rem & ~(8'd1 << remLow);

  assign fetch_hold = (state == SEQ) | stall_in;

  // Stage p0: next-state and next-output selection, flush over stall over normal
  always_comb begin
    stateNext    = state;
    remNext      = rem;
    cntNext      = cnt;
    vld_p0       = uop_valid;
    uopIr_p0     = uop_ir;
    uopReg_p0    = uop_reg;
    uopOffset_p0 = uop_offset;
    first_p0     = first_multiple;
    last_p0      = last_multiple;

    if (flush) begin
      stateNext    = IDLE;
      remNext      = 8'd0;
      cntNext      = 3'd0;
      vld_p0       = 1'b0;
      uopIr_p0     = 16'd0;
      uopReg_p0    = 3'd0;
      uopOffset_p0 = 16'd0;
      first_p0     = 1'b0;
      last_p0      = 1'b0;
    end else if (!stall_in) begin
      unique case (state)
        IDLE: begin
          vld_p0       = 1'b0;
          uopIr_p0     = 16'd0;
          uopReg_p0    = 3'd0;
          uopOffset_p0 = 16'd0;
          first_p0     = 1'b0;
          last_p0      = 1'b0;
          if (ir_valid && !isMulti) begin
            vld_p0   = 1'b1;
            uopIr_p0 = ir_in;
          end else if (ir_valid && mask != 8'd0) begin
            vld_p0    = 1'b1;
            uopIr_p0  = ir_in;
            uopReg_p0 = maskLow;
            first_p0  = 1'b1;
            last_p0   = singleBit(mask);
            remNext   = maskLeft;
            cntNext   = 3'd1;
            stateNext = (maskLeft != 8'd0) ? SEQ : IDLE;
          end
        end
        SEQ: begin
          vld_p0       = 1'b1;
          uopReg_p0    = remLow;
          uopOffset_p0 = {13'd0, cnt};
          first_p0     = 1'b0;
          last_p0      = singleBit(rem);
          remNext      = remLeft;
          cntNext      = cnt + 3'd1;
          stateNext    = (remLeft != 8'd0) ? SEQ : IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Stage p1: registered sequencer state and micro-op outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      rem            <= 8'd0;
      cnt            <= 3'd0;
      uop_valid      <= 1'b0;
      uop_ir         <= 16'd0;
      uop_reg        <= 3'd0;
      uop_offset     <= 16'd0;
      first_multiple <= 1'b0;
      last_multiple  <= 1'b0;
    end else begin
      state          <= stateNext;
      rem            <= remNext;
      cnt            <= cntNext;
      uop_valid      <= vld_p0;
      uop_ir         <= uopIr_p0;
      uop_reg        <= uopReg_p0;
      uop_offset     <= uopOffset_p0;
      first_multiple <= first_p0;
      last_multiple  <= last_p0;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: expected micro-ops are queued as stimulus is driven
// and compared one per clock edge.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir_in;
  logic        ir_valid;
  logic        stall_in;
  logic        flush;
  logic        uop_valid;
  logic [15:0] uop_ir;
  logic [2:0]  uop_reg;
  logic [15:0] uop_offset;
  logic        first_multiple;
  logic        last_multiple;
  logic        fetch_hold;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        full;
    logic        vld;
    logic [15:0] ir;
    logic [2:0]  rg;
    logic [15:0] off;
    logic        first;
    logic        last;
    logic        hold;
  } exp_t;

  exp_t sb[$];

  lmsm_sequencer dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .ir_valid(ir_valid),
    .stall_in(stall_in), .flush(flush), .uop_valid(uop_valid), .uop_ir(uop_ir),
    .uop_reg(uop_reg), .uop_offset(uop_offset), .first_multiple(first_multiple),
    .last_multiple(last_multiple), .fetch_hold(fetch_hold)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push(input logic full, input logic vld, input logic [15:0] ir,
                               input logic [2:0] rg, input int off, input logic first,
                               input logic last, input logic hold);
    exp_t e;
    e.full = full; e.vld = vld; e.ir = ir; e.rg = rg; e.off = 16'(off);
    e.first = first; e.last = last; e.hold = hold;
    sb.push_back(e);
  endfunction

  // Drive one cycle of inputs, take the edge, then compare against the scoreboard head.
  // fetch_hold is compared with stall_in low, so it reflects only the sequencer state.
  task automatic drive_cycle(input logic [15:0] ir, input logic v, input logic st,
                             input logic fl, input string tag);
    exp_t e;
    ir_in = ir; ir_valid = v; stall_in = st; flush = fl;
    #1;
    if (st) begin
      checks++;
      if (fetch_hold !== 1'b1) begin
        errors++;
        $display("FAIL %s fetch_hold_stall: got %b want 1", tag, fetch_hold);
      end
    end
    @(posedge clk);
    #1;
    ir_in = 16'd0; ir_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: no expectation queued", tag);
    end else begin
      e = sb.pop_front();
      if (uop_valid !== e.vld || first_multiple !== e.first || last_multiple !== e.last ||
          fetch_hold !== e.hold) begin
        errors++;
        $display("FAIL %s ctrl: got vld=%b first=%b last=%b hold=%b want vld=%b first=%b last=%b hold=%b",
                 tag, uop_valid, first_multiple, last_multiple, fetch_hold,
                 e.vld, e.first, e.last, e.hold);
      end
      if (e.full) begin
        checks++;
        if (uop_ir !== e.ir || uop_reg !== e.rg || uop_offset !== e.off) begin
          errors++;
          $display("FAIL %s data: got ir=%h reg=%0d off=%0d want ir=%h reg=%0d off=%0d",
                   tag, uop_ir, uop_reg, uop_offset, e.ir, e.rg, e.off);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ir_in = 16'd0; ir_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({uop_valid, uop_ir, uop_reg, uop_offset, first_multiple, last_multiple, fetch_hold} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b ir=%h reg=%0d off=%0d first=%b last=%b hold=%b want all 0",
               uop_valid, uop_ir, uop_reg, uop_offset, first_multiple, last_multiple, fetch_hold);
    end
    stall_in = 1'b1;
    #1;
    checks++;
    if (fetch_hold !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold_follows_stall: got %b want 1", fetch_hold);
    end
    stall_in = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_passthrough();
    push(1, 1, 16'h1234, 0, 0, 0, 0, 0);
    drive_cycle(16'h1234, 1, 0, 0, "pass0");
    push(1, 1, 16'h2345, 0, 0, 0, 0, 0);
    drive_cycle(16'h2345, 1, 0, 0, "pass1");
    push(1, 0, 16'h0000, 0, 0, 0, 0, 0);
    drive_cycle(16'h3456, 0, 0, 0, "invalid");
  endtask

  task automatic test_lm_a5();
    logic [2:0] regs [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    for (int n = 0; n < 4; n++)
      push(1, 1, 16'h62A5, regs[n], n, n == 0, n == 3, n < 3);
    drive_cycle(16'h62A5, 1, 0, 0, "lmA5_0");
    for (int n = 1; n < 4; n++)
      drive_cycle(16'h1111, 1, 0, 0, $sformatf("lmA5_%0d", n));
    push(1, 1, 16'h0050, 0, 0, 0, 0, 0);
    drive_cycle(16'h0050, 1, 0, 0, "lmA5_next");
  endtask

  task automatic test_single_sm();
    push(1, 1, 16'h7080, 7, 0, 1, 1, 0);
    drive_cycle(16'h7080, 1, 0, 0, "sm80");
    push(1, 1, 16'h0050, 0, 0, 0, 0, 0);
    drive_cycle(16'h0050, 1, 0, 0, "sm80_next");
  endtask

  task automatic test_zero_mask();
    push(0, 0, 16'h0000, 0, 0, 0, 0, 0);
    drive_cycle(16'h6200, 1, 0, 0, "mask00");
    push(1, 1, 16'h1050, 0, 0, 0, 0, 0);
    drive_cycle(16'h1050, 1, 0, 0, "mask00_next");
  endtask

  task automatic test_stall();
    for (int n = 0; n < 3; n++)
      push(1, 1, 16'h64FF, 3'(n), n, n == 0, 0, 1);
    push(1, 1, 16'h64FF, 2, 2, 0, 0, 1);
    push(1, 1, 16'h64FF, 2, 2, 0, 0, 1);
    for (int n = 3; n < 8; n++)
      push(1, 1, 16'h64FF, 3'(n), n, 0, n == 7, n < 7);
    drive_cycle(16'h64FF, 1, 0, 0, "ff_0");
    drive_cycle(16'h2222, 1, 0, 0, "ff_1");
    drive_cycle(16'h2222, 1, 0, 0, "ff_2");
    drive_cycle(16'h2222, 1, 1, 0, "ff_stall0");
    drive_cycle(16'h2222, 1, 1, 0, "ff_stall1");
    for (int n = 3; n < 8; n++)
      drive_cycle(16'h2222, 1, 0, 0, $sformatf("ff_%0d", n));
  endtask

  task automatic test_flush();
    push(1, 1, 16'h620F, 0, 0, 1, 0, 1);
    push(1, 1, 16'h620F, 1, 1, 0, 0, 1);
    push(0, 0, 16'h0000, 0, 0, 0, 0, 0);
    push(1, 0, 16'h0000, 0, 0, 0, 0, 0);
    push(1, 1, 16'h0050, 0, 0, 0, 0, 0);
    drive_cycle(16'h620F, 1, 0, 0, "fl_0");
    drive_cycle(16'h3333, 1, 0, 0, "fl_1");
    drive_cycle(16'h3333, 1, 1, 1, "fl_flush");
    drive_cycle(16'h3333, 0, 0, 0, "fl_idle");
    drive_cycle(16'h0050, 1, 0, 0, "fl_next");
  endtask

  task automatic test_reset_mid();
    push(1, 1, 16'h68F0, 4, 0, 1, 0, 1);
    push(1, 1, 16'h68F0, 5, 1, 0, 0, 1);
    drive_cycle(16'h68F0, 1, 0, 0, "rs_0");
    drive_cycle(16'h4444, 1, 0, 0, "rs_1");
    reset = 1'b0;
    #1;
    checks++;
    if ({uop_valid, uop_ir, uop_reg, uop_offset, first_multiple, last_multiple, fetch_hold} !== 39'd0) begin
      errors++;
      $display("FAIL reset_async: got vld=%b ir=%h reg=%0d off=%0d first=%b last=%b hold=%b want all 0",
               uop_valid, uop_ir, uop_reg, uop_offset, first_multiple, last_multiple, fetch_hold);
    end
    #2;
    reset = 1'b1;
    push(1, 1, 16'h0050, 0, 0, 0, 0, 0);
    drive_cycle(16'h0050, 1, 0, 0, "rs_next");
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lm_a5();
    test_single_sm();
    test_zero_mask();
    test_stall();
    test_flush();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
